// File: rtl/timestep_scheduler_pkg.sv
// Shared definitions for the per-timestep sequencer: FSM state encoding and
// stamp defaults used by the scheduler and its settle-window helper.
package timestep_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENCODE = 3'd1,
        S_DRAIN  = 3'd2,
        S_LEAK   = 3'd3,
        S_ADV_E  = 3'd4,
        S_ADV_N  = 3'd5,
        S_FINISH = 3'd6
    } sched_state_t;

    localparam int unsigned STAMP_W_DEF = 4;

    // Wide all-ones; users slice to their own stamp width.
    localparam logic [31:0] NEURON_STAMP_INIT = '1;

endpackage

// File: rtl/timestep_scheduler_quiescence.sv
// Settle-window counter: asserts settled once SETTLE consecutive quiescent
// cycles have been seen while enabled (i.e. while the scheduler is in DRAIN).
module quiescence_detector #(
    parameter int unsigned GROUPS = 16,
    parameter int unsigned SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [GROUPS-1:0] empty_group,
    input  logic              core_idle,
    input  logic              enable,
    output logic              settled
);

    localparam int unsigned CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [CNT_W-1:0] count;
    logic             quiescent;

    always_comb begin
        quiescent = fifo_empty && (&empty_group) && core_idle;
        // The current quiescent cycle completes the window, so compare to SETTLE-1.
        settled   = enable && quiescent && (count == CNT_W'(SETTLE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable && quiescent && !settled) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/timestep_scheduler.sv
// Per-timestep sequencer for the spiking core: encode, drain spike traffic,
// global leak, then advance the encode/neuron stamp pair, for num_steps steps.
module timestep_scheduler
    import timestep_scheduler_pkg::*;
#(
    parameter int unsigned STAMP_W = STAMP_W_DEF,
    parameter int unsigned GROUPS  = 16,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned WDOG_W  = 20
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         num_steps,
    input  logic               encode_finish,
    input  logic               fifo_empty,
    input  logic [GROUPS-1:0]  empty_group,
    input  logic               core_idle,
    input  logic               leak_done,
    output logic               encode_start,
    output logic               leak_req,
    output logic [STAMP_W-1:0] encode_stamp,
    output logic [STAMP_W-1:0] neuron_stamp,
    output logic               tref_event_generate,
    output logic               encode_event_generate,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [7:0]         steps_left
);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [WDOG_W-1:0] wdog;
    logic              finish_cap;
    logic              settled;
    logic              abort_hit;
    logic              watched;
    logic              wdog_expired;

    quiescence_detector #(
        .GROUPS (GROUPS),
        .SETTLE (SETTLE)
    ) u_quiescence (
        .clk         (CLK),
        .rst_n       (RST_N),
        .fifo_empty  (fifo_empty),
        .empty_group (empty_group),
        .core_idle   (core_idle),
        .enable      (state == S_DRAIN),
        .settled     (settled)
    );

    always_comb begin
        next_state   = state;
        abort_hit    = abort && (state != S_IDLE);
        watched      = (state == S_ENCODE) || (state == S_DRAIN) || (state == S_LEAK);
        wdog_expired = watched && (wdog == '1);

        case (state)
            S_IDLE:   if (start) next_state = (num_steps != '0) ? S_ENCODE : S_FINISH;
            S_ENCODE: if (finish_cap || encode_finish) next_state = S_DRAIN;
            S_DRAIN:  if (settled) next_state = S_LEAK;
            S_LEAK:   if (leak_done) next_state = S_ADV_E;
            S_ADV_E:  next_state = S_ADV_N;
            S_ADV_N:  next_state = (steps_left == '0) ? S_FINISH : S_ENCODE;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase

        // Priority: abort over watchdog over the normal transition.
        if (wdog_expired) next_state = S_IDLE;
        if (abort_hit)    next_state = S_IDLE;

        busy                  = (state != S_IDLE);
        leak_req              = (state == S_LEAK);
        tref_event_generate   = (state == S_ADV_E);
        encode_event_generate = (state == S_ADV_E);
        done                  = (state == S_FINISH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            encode_start <= 1'b0;
            encode_stamp <= '0;
            neuron_stamp <= NEURON_STAMP_INIT[STAMP_W-1:0];
            timeout      <= 1'b0;
            steps_left   <= '0;
            finish_cap   <= 1'b0;
            wdog         <= '0;
        end else begin
            state        <= next_state;
            encode_start <= (next_state == S_ENCODE) && (state != S_ENCODE);

            // Value equals cycles spent in the current visit, entry cycle included.
            if (state != next_state) begin
                wdog <= WDOG_W'(1);
            end else if (wdog != '1) begin
                wdog <= wdog + WDOG_W'(1);
            end

            if (state == S_IDLE && start) begin
                steps_left <= num_steps;
                timeout    <= 1'b0;
            end else if (abort_hit) begin
                steps_left <= '0;
            end else if (state == S_ADV_E) begin
                steps_left <= steps_left - 8'd1;
            end

            if (wdog_expired && !abort_hit) begin
                timeout <= 1'b1;
            end

            if (state == S_ADV_E && !abort_hit) begin
                encode_stamp <= encode_stamp + STAMP_W'(1);
            end
            if (state == S_ADV_N && !abort_hit) begin
                neuron_stamp <= neuron_stamp + STAMP_W'(1);
            end

            if (next_state == S_IDLE || (state == S_ENCODE && next_state != S_ENCODE)) begin
                finish_cap <= 1'b0;
            end else if (encode_finish && state != S_IDLE) begin
                finish_cap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timestep_scheduler.sv
// Self-checking bench for timestep_scheduler: the bench plays encoder, spike
// fabric and leak engine, and predicts every output from the timestep timeline.
module tb_timestep_scheduler;

    localparam int unsigned STAMP_W    = 4;
    localparam int unsigned GROUPS     = 16;
    localparam int unsigned SETTLE     = 4;
    localparam int unsigned WDOG_W     = 6;
    localparam int          WDOG_LIMIT = (1 << WDOG_W) - 1;
    localparam int          STAMP_MOD  = 1 << STAMP_W;

    logic               CLK;
    logic               RST_N;
    logic               start;
    logic               abort;
    logic [7:0]         num_steps;
    logic               encode_finish;
    logic               fifo_empty;
    logic [GROUPS-1:0]  empty_group;
    logic               core_idle;
    logic               leak_done;
    logic               encode_start;
    logic               leak_req;
    logic [STAMP_W-1:0] encode_stamp;
    logic [STAMP_W-1:0] neuron_stamp;
    logic               tref_event_generate;
    logic               encode_event_generate;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [7:0]         steps_left;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_enc  = 0;
    int exp_neu  = STAMP_MOD - 1;
    int cnt_es   = 0;
    int cnt_tref = 0;
    int cnt_ev   = 0;
    int cnt_done = 0;

    timestep_scheduler #(
        .STAMP_W (STAMP_W),
        .GROUPS  (GROUPS),
        .SETTLE  (SETTLE),
        .WDOG_W  (WDOG_W)
    ) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .start                 (start),
        .abort                 (abort),
        .num_steps             (num_steps),
        .encode_finish         (encode_finish),
        .fifo_empty            (fifo_empty),
        .empty_group           (empty_group),
        .core_idle             (core_idle),
        .leak_done             (leak_done),
        .encode_start          (encode_start),
        .leak_req              (leak_req),
        .encode_stamp          (encode_stamp),
        .neuron_stamp          (neuron_stamp),
        .tref_event_generate   (tref_event_generate),
        .encode_event_generate (encode_event_generate),
        .busy                  (busy),
        .done                  (done),
        .timeout               (timeout),
        .steps_left            (steps_left)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (encode_start === 1'b1)          cnt_es++;
        if (tref_event_generate === 1'b1)   cnt_tref++;
        if (encode_event_generate === 1'b1) cnt_ev++;
        if (done === 1'b1)                  cnt_done++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One run of n timesteps. enc_lat/leak_lat < 0 means random latency.
    // glitch_mode: 0 none, 1 random drops, 2 empty_group[7] drop after 3 quiet cycles.
    // stop_step >= 0 ends the run in that step's LEAK by abort or by withholding leak_done.
    task automatic run_steps(input string tag, input int n, input int enc_lat, input int leak_lat,
                             input int glitch_mode, input int stop_step, input bit by_abort);
        int es0, tr0, ev0, dn0, lat, q_run, dcyc, idx, exp_es, exp_tr;
        bit q, stopped;
        es0 = cnt_es; tr0 = cnt_tref; ev0 = cnt_ev; dn0 = cnt_done;
        stopped   = 1'b0;
        num_steps = 8'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < n && !stopped; s++) begin
            n_checks++;
            if ({encode_start, busy, timeout} !== 3'b110) begin
                n_fail++;
                $display("FAIL %s step_entry s=%0d: {encode_start,busy,timeout}=%b want 110", tag, s, {encode_start, busy, timeout});
            end
            n_checks++;
            if (steps_left !== 8'(n - s)) begin
                n_fail++;
                $display("FAIL %s steps_left s=%0d: got %0d want %0d", tag, s, steps_left, n - s);
            end
            n_checks++;
            if ({encode_stamp, neuron_stamp} !== {STAMP_W'(exp_enc), STAMP_W'(exp_neu)}) begin
                n_fail++;
                $display("FAIL %s stamps s=%0d: got enc=%0d neu=%0d want enc=%0d neu=%0d", tag, s, encode_stamp, neuron_stamp, exp_enc, exp_neu);
            end

            lat = (enc_lat < 0) ? int'($urandom_range(0, 6)) : enc_lat;
            for (int i = 0; i < lat; i++) begin
                tick();
                n_checks++;
                if ({encode_start, leak_req} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s encode_wait s=%0d: {encode_start,leak_req}=%b want 00", tag, s, {encode_start, leak_req});
                end
            end
            encode_finish = 1'b1;
            tick();
            encode_finish = 1'b0;

            // DRAIN: leak_req may only rise after SETTLE consecutive quiet cycles.
            q_run = 0;
            dcyc  = 0;
            while (q_run < int'(SETTLE)) begin
                q = 1'b1;
                if (glitch_mode == 1 && dcyc < 12) q = ($urandom_range(0, 3) != 0);
                if (glitch_mode == 2) q = (dcyc != 3);
                fifo_empty  = 1'b1;
                core_idle   = 1'b1;
                empty_group = '1;
                if (!q) begin
                    if (glitch_mode == 2) begin
                        empty_group[7] = 1'b0;
                    end else begin
                        case ($urandom_range(0, 2))
                            0:       fifo_empty = 1'b0;
                            1:       core_idle  = 1'b0;
                            default: begin
                                idx = int'($urandom_range(0, GROUPS - 1));
                                empty_group[idx] = 1'b0;
                            end
                        endcase
                    end
                end
                n_checks++;
                if (leak_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s drain_wait s=%0d c=%0d: leak_req=%b want 0", tag, s, dcyc, leak_req);
                end
                tick();
                q_run = q ? q_run + 1 : 0;
                dcyc++;
            end
            fifo_empty  = 1'b1;
            core_idle   = 1'b1;
            empty_group = '1;
            n_checks++;
            if (leak_req !== 1'b1) begin
                n_fail++;
                $display("FAIL %s leak_rise s=%0d: leak_req=%b want 1", tag, s, leak_req);
            end

            if (s == stop_step) begin
                stopped = 1'b1;
                if (by_abort) begin
                    lat = int'($urandom_range(0, 3));
                    for (int i = 0; i < lat; i++) begin
                        tick();
                        n_checks++;
                        if (leak_req !== 1'b1) begin
                            n_fail++;
                            $display("FAIL %s leak_hold s=%0d: leak_req=%b want 1", tag, s, leak_req);
                        end
                    end
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    n_checks++;
                    if ({busy, leak_req, done, steps_left} !== 11'd0) begin
                        n_fail++;
                        $display("FAIL %s abort_state: busy=%b leak_req=%b done=%b steps_left=%0d want all 0", tag, busy, leak_req, done, steps_left);
                    end
                end else begin
                    for (int i = 1; i < WDOG_LIMIT; i++) begin
                        tick();
                        n_checks++;
                        if ({leak_req, timeout} !== 2'b10) begin
                            n_fail++;
                            $display("FAIL %s wdog_wait c=%0d: {leak_req,timeout}=%b want 10", tag, i, {leak_req, timeout});
                        end
                    end
                    tick();
                    n_checks++;
                    if ({timeout, busy, leak_req, done} !== 4'b1000) begin
                        n_fail++;
                        $display("FAIL %s wdog_expire: {timeout,busy,leak_req,done}=%b want 1000", tag, {timeout, busy, leak_req, done});
                    end
                end
                n_checks++;
                if ({encode_stamp, neuron_stamp} !== {STAMP_W'(exp_enc), STAMP_W'(exp_neu)}) begin
                    n_fail++;
                    $display("FAIL %s stamps_held: got enc=%0d neu=%0d want enc=%0d neu=%0d", tag, encode_stamp, neuron_stamp, exp_enc, exp_neu);
                end
            end else begin
                lat = (leak_lat < 0) ? int'($urandom_range(0, 4)) : leak_lat;
                for (int i = 0; i < lat; i++) begin
                    tick();
                    n_checks++;
                    if (leak_req !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s leak_hold s=%0d: leak_req=%b want 1", tag, s, leak_req);
                    end
                end
                leak_done = 1'b1;
                tick();
                leak_done = 1'b0;
                n_checks++;
                if ({tref_event_generate, encode_event_generate, leak_req, encode_start, encode_stamp, steps_left}
                    !== {4'b1100, STAMP_W'(exp_enc), 8'(n - s)}) begin
                    n_fail++;
                    $display("FAIL %s adv_e s=%0d: tref=%b ev=%b leak=%b es=%b enc=%0d left=%0d want 1 1 0 0 %0d %0d",
                             tag, s, tref_event_generate, encode_event_generate, leak_req, encode_start, encode_stamp, steps_left, exp_enc, n - s);
                end
                tick();
                exp_enc = (exp_enc + 1) % STAMP_MOD;
                n_checks++;
                if ({tref_event_generate, encode_event_generate, encode_stamp, neuron_stamp, steps_left}
                    !== {2'b00, STAMP_W'(exp_enc), STAMP_W'(exp_neu), 8'(n - s - 1)}) begin
                    n_fail++;
                    $display("FAIL %s adv_n s=%0d: tref=%b ev=%b enc=%0d neu=%0d left=%0d want 0 0 %0d %0d %0d",
                             tag, s, tref_event_generate, encode_event_generate, encode_stamp, neuron_stamp, steps_left, exp_enc, exp_neu, n - s - 1);
                end
                tick();
                exp_neu = (exp_neu + 1) % STAMP_MOD;
                n_checks++;
                if (neuron_stamp !== STAMP_W'(exp_neu)) begin
                    n_fail++;
                    $display("FAIL %s neuron_adv s=%0d: got %0d want %0d", tag, s, neuron_stamp, exp_neu);
                end
                if (s == n - 1) begin
                    n_checks++;
                    if ({done, busy, encode_start} !== 3'b110) begin
                        n_fail++;
                        $display("FAIL %s finish: {done,busy,encode_start}=%b want 110", tag, {done, busy, encode_start});
                    end
                    tick();
                    n_checks++;
                    if ({done, busy} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL %s idle_after: {done,busy}=%b want 00", tag, {done, busy});
                    end
                end
            end
        end
        exp_es = stopped ? stop_step + 1 : n;
        exp_tr = stopped ? stop_step : n;
        n_checks++;
        if ({cnt_es - es0, cnt_tref - tr0, cnt_ev - ev0, cnt_done - dn0} !== {exp_es, exp_tr, exp_tr, stopped ? 0 : 1}) begin
            n_fail++;
            $display("FAIL %s pulse_counts: es=%0d tref=%0d ev=%0d done=%0d want %0d %0d %0d %0d", tag,
                     cnt_es - es0, cnt_tref - tr0, cnt_ev - ev0, cnt_done - dn0, exp_es, exp_tr, exp_tr, stopped ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, leak_req, encode_start, tref_event_generate, encode_event_generate, timeout} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000", {busy, done, leak_req, encode_start, tref_event_generate, encode_event_generate, timeout});
        end
        n_checks++;
        if ({encode_stamp, neuron_stamp} !== {STAMP_W'(0), STAMP_W'(STAMP_MOD - 1)}) begin
            n_fail++;
            $display("FAIL reset_stamps: got enc=%0d neu=%0d want 0 15", encode_stamp, neuron_stamp);
        end
        n_checks++;
        if (steps_left !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_steps_left: got %0d want 0", steps_left);
        end
    endtask

    task automatic test_basic_run();
        run_steps("basic", 3, 5, 2, 0, -1, 1'b0);
        n_checks++;
        if ({encode_stamp, neuron_stamp, busy} !== {4'd3, 4'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_end: enc=%0d neu=%0d busy=%b want 3 2 0", encode_stamp, neuron_stamp, busy);
        end
    endtask

    task automatic test_zero_steps();
        num_steps = 8'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, busy, encode_start} !== 3'b110) begin
            n_fail++;
            $display("FAIL zero_finish: {done,busy,encode_start}=%b want 110", {done, busy, encode_start});
        end
        tick();
        n_checks++;
        if ({done, busy, encode_stamp, neuron_stamp} !== {2'b00, STAMP_W'(exp_enc), STAMP_W'(exp_neu)}) begin
            n_fail++;
            $display("FAIL zero_idle: done=%b busy=%b enc=%0d neu=%0d want 0 0 %0d %0d", done, busy, encode_stamp, neuron_stamp, exp_enc, exp_neu);
        end
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({busy, done, encode_start, encode_stamp, neuron_stamp} !== {3'b000, STAMP_W'(exp_enc), STAMP_W'(exp_neu)}) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b done=%b es=%b enc=%0d neu=%0d want 0 0 0 %0d %0d", busy, done, encode_start, encode_stamp, neuron_stamp, exp_enc, exp_neu);
        end
    endtask

    task automatic test_async_reset();
        num_steps = 8'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 RST_N = 1'b0;
        #1;
        exp_enc = 0;
        exp_neu = STAMP_MOD - 1;
        n_checks++;
        if ({busy, encode_start, leak_req, done, timeout, steps_left, encode_stamp, neuron_stamp}
            !== {5'b00000, 8'd0, STAMP_W'(exp_enc), STAMP_W'(exp_neu)}) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b es=%b leak=%b done=%b to=%b left=%0d enc=%0d neu=%0d want 0 0 0 0 0 0 0 15",
                     busy, encode_start, leak_req, done, timeout, steps_left, encode_stamp, neuron_stamp);
        end
        #1 RST_N = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        run_steps("wrap20", 20, -1, -1, 0, -1, 1'b0);
        n_checks++;
        if ({encode_stamp, neuron_stamp} !== {4'd4, 4'd3}) begin
            n_fail++;
            $display("FAIL wrap_end: enc=%0d neu=%0d want 4 3", encode_stamp, neuron_stamp);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            run_steps("random", int'($urandom_range(1, 5)), -1, -1, 1, -1, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, got hang want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        RST_N         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        num_steps     = 8'd0;
        encode_finish = 1'b0;
        fifo_empty    = 1'b1;
        empty_group   = '1;
        core_idle     = 1'b1;
        leak_done     = 1'b0;
        repeat (3) @(posedge CLK);
        #4 RST_N = 1'b1;
        tick();

        test_reset();
        test_basic_run();
        run_steps("same_cycle_finish", 1, 0, 0, 0, -1, 1'b0);
        run_steps("settle_glitch", 1, 2, 1, 2, -1, 1'b0);
        test_zero_steps();
        test_abort_idle();
        run_steps("abort_leak", 5, -1, -1, 0, 1, 1'b1);
        run_steps("resume_after_abort", 2, -1, -1, 0, -1, 1'b0);
        run_steps("watchdog", 2, -1, -1, 0, 0, 1'b0);
        run_steps("resume_after_timeout", 1, -1, -1, 0, -1, 1'b0);
        test_async_reset();
        test_wrap();
        test_random_runs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timestep_scheduler.md
Name: timestep_scheduler

Overview:
- Top-level per-timestep sequencer for the spiking core. It owns the encode/neuron timestamp pair and runs each timestep through a fixed order: encode, drain spike traffic, global leak, advance stamps.
- It replaces ad-hoc stamp advancing with an explicit FSM. The FSM has a programmable step count, a quiescence settle window, a watchdog and an abort.
- It sits between the host control registers and the encoder, spike FIFO, neuron groups and refractory logic.

Parameters:
- STAMP_W, 4, width of encode_stamp / neuron_stamp (modulo-2^STAMP_W wrap)
- GROUPS, 16, number of neuron groups reporting empty
- SETTLE, 4, consecutive quiescent cycles required before leaving DRAIN (>=1)
- WDOG_W, 20, watchdog counter width; timeout at all-ones

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a run of num_steps timesteps (ignored unless IDLE)
- abort  in  1  pulse: terminate run, highest priority
- num_steps  in  8  timesteps per run, sampled on accepted start
- encode_finish  in  1  pulse from encoder: current timestep's input spikes issued
- fifo_empty  in  1  spike FIFO empty
- empty_group  in  GROUPS  per-group event queue empty
- core_idle  in  1  neuron update controller idle
- leak_done  in  1  pulse: global leak pass complete
- encode_start  out  1  pulse: encoder begins the timestep
- leak_req  out  1  level: held high in LEAK until leak_done
- encode_stamp  out  STAMP_W  current encode timestamp
- neuron_stamp  out  STAMP_W  current neuron timestamp
- tref_event_generate  out  1  pulse: refractory update event
- encode_event_generate  out  1  pulse: encode event for new timestep
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion
- timeout  out  1  sticky watchdog error; cleared on next accepted start
- steps_left  out  8  remaining timesteps including the current one

Behaviour:
- Reset values: state IDLE; all pulses and leak_req 0; encode_stamp 0; neuron_stamp all ones (15); busy 0; timeout 0; steps_left 0; internal finish capture 0.
- FSM states: IDLE, ENCODE, DRAIN, LEAK, ADV_E, ADV_N, FINISH.
- IDLE: on start with num_steps!=0, load steps_left=num_steps, clear timeout, pulse encode_start the next cycle, go to ENCODE. On start with num_steps==0, go to FINISH (done pulse, no encode).
- ENCODE: wait for captured encode_finish, then go to DRAIN. encode_finish is sticky-captured in any busy state, so an early pulse is not lost. The capture clears on leaving ENCODE.
- DRAIN: quiescent = fifo_empty & (&empty_group) & core_idle.
  - Counter increments while quiescent and resets to 0 on any non-quiescent cycle.
  - On reaching SETTLE, go to LEAK.
- LEAK: assert leak_req until leak_done is seen (same cycle counts), then go to ADV_E.
- ADV_E (1 cycle): encode_stamp+=1 (wraps), tref_event_generate=1, encode_event_generate=1, steps_left-=1.
- ADV_N (1 cycle): neuron_stamp+=1 (wraps). neuron_stamp always updates exactly one cycle after encode_stamp.
  - If steps_left==0, go to FINISH.
  - Otherwise pulse encode_start and go to ENCODE.
- FINISH: done=1 for one cycle, then go to IDLE.
- Watchdog: counts cycles spent in any single ENCODE/DRAIN/LEAK visit and resets on each state change.
  - At all-ones: set timeout, deassert leak_req, go to IDLE with no done pulse.
  - Stamps hold their values.
- abort: from any busy state, go to IDLE on the next edge. leak_req and pulses drop, steps_left=0, stamps hold, no done. abort in IDLE has no effect.
- Simultaneous events:
  - abort beats everything.
  - Watchdog expiry beats the normal transition in the same cycle.
  - encode_finish and encode_start in the same cycle is illegal from the encoder side; the capture is still set.
- Asynchronous reset mid-run returns everything to the reset values immediately.

Decomposition:
- Shared package: FSM state encoding (3-bit enum), STAMP_W default, and the reset constant NEURON_STAMP_INIT = all ones.
- One sub-module, quiescence_detector, holds the DRAIN settle counter. Interface: fifo_empty, empty_group, core_idle, enable, settled.

Test Plan:
- num_steps=3, encoder answers 5 cycles after encode_start, leak_done 2 cycles after leak_req -> exactly 3 encode_start, 3 tref/encode event pulses, encode_stamp 0→3, neuron_stamp 15→2, one done, busy low afterwards.
- In DRAIN, drop empty_group[7] for 1 cycle after 3 quiescent cycles (SETTLE=4) -> leak_req rises only 4 cycles after the glitch ends.
- encode_finish pulsed in the same cycle as encode_start -> capture holds, and DRAIN is entered on the next cycle.
- Run 20 steps from reset -> encode_stamp wraps 15→0 at step 16, and neuron_stamp ends at 3.
- abort during LEAK -> leak_req low next cycle, IDLE, no done, stamps unchanged. A new start then resumes from the held stamps.
- Withhold leak_done with WDOG_W reduced to 6 -> timeout=1 after 63 cycles in LEAK, IDLE, no done. Next start clears timeout.
